dmac_tcdm_req_buffer: RTL and testbench

//  Elastic request buffer between one DMA TCDM init port and the cluster TCDM interconnect; one instance per port (4 per DMA).

---
 rtl/dmac_tcdm_req_buffer.sv | 197 +++++++++++++++++++
 tb/tb_dmac_tcdm_req_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_tcdm_req_buffer.sv
// ---------------------------------------------------------------------------
// dmac_tcdm_req_buffer
//   Elastic request buffer between one DMA TCDM init port and the cluster
//   TCDM interconnect. Requests are queued in a small FIFO so that
//   interconnect grant stalls do not back-pressure the DMA directly. An
//   outstanding-credit counter caps granted-but-unanswered transactions.
//   Responses are forwarded to the DMA in order.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_*                      DMA side: request/payload in, gnt and response out
//   out_*                     interconnect side: request/payload out, gnt and
//                             response in
//   fill_o                    FIFO occupancy (0..DEPTH)
//   busy_o                    FIFO non-empty or transactions still outstanding
//   err_o                     sticky: response arrived with nothing outstanding
//
// Configuration macro
//   DMAC_TCDM_BUF_BYPASS_EN   when defined, an empty FIFO with spare credit
//                             forwards in_req_i to out_* in the same cycle.
// ---------------------------------------------------------------------------
module dmac_tcdm_req_buffer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_req_i,
  input  logic [ADDR_WIDTH-1:0]   in_add_i,
  input  logic                    in_wen_i,
  input  logic [BE_WIDTH-1:0]     in_be_i,
  input  logic [DATA_WIDTH-1:0]   in_wdata_i,
  output logic                    in_gnt_o,
  output logic                    in_r_valid_o,
  output logic [DATA_WIDTH-1:0]   in_r_rdata_o,
  output logic                    out_req_o,
  output logic [ADDR_WIDTH-1:0]   out_add_o,
  output logic                    out_wen_o,
  output logic [BE_WIDTH-1:0]     out_be_o,
  output logic [DATA_WIDTH-1:0]   out_wdata_o,
  input  logic                    out_gnt_i,
  input  logic                    out_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   out_r_rdata_i,
  output logic [$clog2(DEPTH):0]  fill_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = 1 + ADDR_WIDTH + BE_WIDTH + DATA_WIDTH;

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [3:0]       OS_ZERO  = 4'd0;
  localparam logic [3:0]       OS_ONE   = 4'd1;
  localparam logic [3:0]       OS_MAX   = 4'(MAX_OUTSTANDING);

  // Entry layout: {wen, add, be, wdata}
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [3:0]       r_outstanding;
  logic             r_err;

  logic             w_empty;
  logic             w_full;
  logic             w_credit_ok;
  logic             w_bypass;
  logic             w_issue_req;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_rsp_ok;
  logic [ENT_W-1:0] w_in_entry;
  logic [ENT_W-1:0] w_head_entry;
  logic [ENT_W-1:0] w_issue_entry;

  assign w_empty      = (r_count == CNT_ZERO);
  assign w_full       = (r_count == CNT_FULL);
  assign w_credit_ok  = (r_outstanding < OS_MAX);
  assign w_in_entry   = {in_wen_i, in_add_i, in_be_i, in_wdata_i};
  assign w_head_entry = r_mem[r_rd_ptr];

`ifdef DMAC_TCDM_BUF_BYPASS_EN
  // Bypass window: nothing queued ahead and a credit is available.
  assign w_bypass = w_empty & w_credit_ok;
`else
  assign w_bypass = 1'b0;
`endif

  // Choose the request presented to the interconnect (FIFO head or bypass).
  always_comb begin
    w_issue_req   = 1'b0;
    w_issue_entry = w_head_entry;
    if (w_bypass) begin
      w_issue_req   = in_req_i;
      w_issue_entry = w_in_entry;
    end else begin
      w_issue_req   = ~w_empty & w_credit_ok;
      w_issue_entry = w_head_entry;
    end
  end

  // A granted bypass request is consumed directly and never enters the FIFO;
  // an ungranted one falls through to a normal push.
  assign w_fire   = w_issue_req & out_gnt_i;
  assign w_pop    = w_fire & ~w_bypass;
  assign w_push   = in_req_i & ~w_full & ~(w_bypass & out_gnt_i);
  assign w_rsp_ok = out_r_valid_i & (r_outstanding != OS_ZERO);

  // Drive the interconnect payload, forced to zero while no request is valid.
  always_comb begin
    out_req_o = w_issue_req;
    {out_wen_o, out_add_o, out_be_o, out_wdata_o} = {ENT_W{1'b0}};
    if (w_issue_req) begin
      {out_wen_o, out_add_o, out_be_o, out_wdata_o} = w_issue_entry;
    end else begin
      {out_wen_o, out_add_o, out_be_o, out_wdata_o} = {ENT_W{1'b0}};
    end
  end

  // Response path back to the DMA; orphan responses are suppressed.
  always_comb begin
    in_r_valid_o = w_rsp_ok;
    in_r_rdata_o = {DATA_WIDTH{1'b0}};
    if (w_rsp_ok) begin
      in_r_rdata_o = out_r_rdata_i;
    end else begin
      in_r_rdata_o = {DATA_WIDTH{1'b0}};
    end
  end

  assign in_gnt_o = ~w_full;
  assign fill_o   = r_count;
  assign busy_o   = ~w_empty | (r_outstanding != OS_ZERO);
  assign err_o    = r_err;

  // FIFO storage; only entries between the pointers are ever read, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outstanding credit counter; issue is blocked at the cap so it cannot overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= OS_ZERO;
    end else begin
      case ({w_fire, w_rsp_ok})
        2'b10:   r_outstanding <= r_outstanding + OS_ONE;
        2'b01:   r_outstanding <= r_outstanding - OS_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Sticky error: a response arrived while nothing was outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (out_r_valid_i & ~w_rsp_ok) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

endmodule

// File: tb/tb_dmac_tcdm_req_buffer.sv
module tb_dmac_tcdm_req_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 4;
`ifdef DMAC_TCDM_BUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_req;
  logic [31:0] in_add;
  logic        in_wen;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic        in_gnt;
  logic        in_r_valid;
  logic [31:0] in_r_rdata;
  logic        out_req;
  logic [31:0] out_add;
  logic        out_wen;
  logic [3:0]  out_be;
  logic [31:0] out_wdata;
  logic        out_gnt;
  logic        out_r_valid;
  logic [31:0] out_r_rdata;
  logic [2:0]  fill;
  logic        busy;
  logic        err;

  dmac_tcdm_req_buffer dut (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(in_req), .in_add_i(in_add), .in_wen_i(in_wen), .in_be_i(in_be),
    .in_wdata_i(in_wdata), .in_gnt_o(in_gnt), .in_r_valid_o(in_r_valid),
    .in_r_rdata_o(in_r_rdata),
    .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen), .out_be_o(out_be),
    .out_wdata_o(out_wdata), .out_gnt_i(out_gnt), .out_r_valid_i(out_r_valid),
    .out_r_rdata_i(out_r_rdata),
    .fill_o(fill), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ent_t;

  ent_t q[$];
  int   os = 0;
  bit   m_err = 1'b0;

  bit   e_req, e_gnt, e_byp, e_rv;
  ent_t e_pay;

  // Compute expectations mid-cycle and compare every DUT output.
  always @(negedge clk) begin
    e_gnt = (q.size() < DEPTH);
    e_byp = BYPASS && (q.size() == 0) && (os < MAXO);
    if (e_byp) begin
      e_req = in_req;
      e_pay = '{wen: in_wen, add: in_add, be: in_be, wdata: in_wdata};
    end else begin
      e_req = (q.size() != 0) && (os < MAXO);
      e_pay = (q.size() != 0) ? q[0] : '0;
    end
    if (!e_req) e_pay = '0;
    e_rv = out_r_valid && (os != 0);
    chk("cyc_out_req",   out_req,   e_req);
    chk("cyc_out_add",   out_add,   e_pay.add);
    chk("cyc_out_wen",   out_wen,   e_pay.wen);
    chk("cyc_out_be",    out_be,    e_pay.be);
    chk("cyc_out_wdata", out_wdata, e_pay.wdata);
    chk("cyc_in_gnt",    in_gnt,    e_gnt);
    chk("cyc_in_rvalid", in_r_valid, e_rv);
    chk("cyc_in_rdata",  in_r_rdata, e_rv ? out_r_rdata : 32'h0);
    chk("cyc_fill",      fill,      q.size());
    chk("cyc_busy",      busy,      (q.size() != 0) || (os != 0));
    chk("cyc_err",       err,       m_err);
  end

  // Advance the model with the inputs that were stable during the cycle.
  always @(posedge clk) begin
    bit fire, push;
    if (rst) begin
      q.delete();
      os    = 0;
      m_err = 1'b0;
    end else begin
      fire = e_req && out_gnt;
      push = in_req && e_gnt && !(e_byp && fire);
      if (out_r_valid && os == 0) m_err = 1'b1;
      if (fire && !e_byp) void'(q.pop_front());
      if (push) q.push_back('{wen: in_wen, add: in_add, be: in_be, wdata: in_wdata});
      if (fire && !e_rv) os++;
      else if (!fire && e_rv) os--;
    end
  end

  // ---------------- directed stimulus ----------------
  int fires;

  initial begin
    rst = 1'b1; in_req = 1'b0; in_add = 32'h0; in_wen = 1'b0; in_be = 4'h0;
    in_wdata = 32'h0; out_gnt = 1'b0; out_r_valid = 1'b0; out_r_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // 1. reset state
    chk("rst_out_req", out_req, 1'b0);
    chk("rst_in_gnt",  in_gnt,  1'b1);
    chk("rst_fill",    fill,    3'd0);
    chk("rst_busy",    busy,    1'b0);
    chk("rst_err",     err,     1'b0);

    // 2. four writes with no grant, then drain in order
    for (int i = 0; i < 4; i++) begin
      in_req = 1'b1; in_wen = 1'b0; in_add = 32'h10 + 32'(4 * i);
      in_be = 4'hF; in_wdata = 32'hA000_0000 + 32'(i);
      #1 chk("wr_gnt", in_gnt, 1'b1);
      tick();
    end
    in_add = 32'h20;
    #1 chk("full_fill", fill, 3'd4);
    chk("full_gnt", in_gnt, 1'b0);
    tick();
    in_req = 1'b0; out_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_req", out_req, 1'b1);
      chk("drain_add", out_add, 32'h10 + 32'(4 * i));
      chk("drain_wdata", out_wdata, 32'hA000_0000 + 32'(i));
      tick();
    end
    out_gnt = 1'b0;
    #1 chk("drained_fill", fill, 3'd0);
    out_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("wr_rsp", in_r_valid, 1'b1);
      tick();
    end
    out_r_valid = 1'b0;
    #1 chk("idle_busy", busy, 1'b0);

    // 3. six reads, no responses: credit cap stops issue at 4
    out_gnt = 1'b1; fires = 0;
    for (int i = 0; i < 8; i++) begin
      in_req = (i < 6); in_wen = 1'b1; in_add = 32'h100 + 32'(4 * i); in_wdata = 32'h0;
      #1 if (out_req && out_gnt) fires++;
      tick();
    end
    in_req = 1'b0;
    #1 chk("cap_fires", fires, 4);
    chk("cap_req", out_req, 1'b0);
    chk("cap_fill", fill, 3'd2);
    out_r_valid = 1'b1; out_r_rdata = 32'hDEADBEEF;
    #1 chk("rsp_valid", in_r_valid, 1'b1);
    chk("rsp_rdata", in_r_rdata, 32'hDEADBEEF);
    chk("rsp_req_same", out_req, 1'b0);
    tick();
    out_r_valid = 1'b0; out_r_rdata = 32'h0;
    #1 chk("rsp_next_req", out_req, 1'b1);
    chk("rsp_next_add", out_add, 32'h110);
    tick();

    // 4. simultaneous pop+response at outstanding 2; simultaneous push+pop at fill 2
    out_gnt = 1'b0; out_r_valid = 1'b1;
    tick();
    tick();
    out_gnt = 1'b1;
    #1 chk("pr_req", out_req, 1'b1);
    chk("pr_add", out_add, 32'h114);
    chk("pr_rvalid", in_r_valid, 1'b1);
    tick();
    out_gnt = 1'b0; out_r_valid = 1'b0;
    #1 chk("pr_fill", fill, 3'd0);
    chk("pr_busy", busy, 1'b1);
    in_req = 1'b1; in_wen = 1'b1; in_add = 32'h200;
    tick();
    in_add = 32'h204;
    tick();
    in_add = 32'h208; out_gnt = 1'b1;
    #1 chk("pp_fill_before", fill, 3'd2);
    chk("pp_req", out_req, 1'b1);
    tick();
    in_req = 1'b0;
    #1 chk("pp_fill_after", fill, 3'd2);
    tick();
    #1 chk("os_cap_fill", fill, 3'd1);
    chk("os_cap_req", out_req, 1'b0);
    out_gnt = 1'b0;

    // 5. reset mid-operation, then a stray response
    out_r_valid = 1'b1;
    tick();
    out_r_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fill", fill, 3'd0);
    out_r_valid = 1'b1; out_r_rdata = 32'h1234;
    #1 chk("orphan_rvalid", in_r_valid, 1'b0);
    chk("orphan_err_pre", err, 1'b0);
    tick();
    out_r_valid = 1'b0; out_r_rdata = 32'h0;
    #1 chk("orphan_err", err, 1'b1);
    repeat (3) tick();
    chk("orphan_err_sticky", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("err_cleared", err, 1'b0);

    // 6. single read into empty buffer with grant asserted
    out_gnt = 1'b1; in_req = 1'b1; in_wen = 1'b1; in_add = 32'h20; in_be = 4'hF;
`ifdef DMAC_TCDM_BUF_BYPASS_EN
    #1 chk("byp_req", out_req, 1'b1);
    chk("byp_gnt", in_gnt, 1'b1);
    chk("byp_add", out_add, 32'h20);
    tick();
    in_req = 1'b0;
    #1 chk("byp_fill", fill, 3'd0);
`else
    #1 chk("nobyp_req", out_req, 1'b0);
    chk("nobyp_gnt", in_gnt, 1'b1);
    tick();
    in_req = 1'b0;
    #1 chk("nobyp_req_next", out_req, 1'b1);
    chk("nobyp_add", out_add, 32'h20);
    chk("nobyp_fill", fill, 3'd1);
`endif
    tick();
    out_gnt = 1'b0; out_r_valid = 1'b1;
    tick();
    out_r_valid = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
